t_toggle_sequencer: RTL and testbench

Controller that drives a bank of WIDTH external T flip-flops (`t_flipflop` instances sharing `clk`/`reset`) from a current state to a requested target state. It issues at most one one-hot toggle strobe per cycle, spaced by a programmable gap, and keeps a cycle-exact mirror of the bank's outputs. It sits between a command source using a valid/ready handshake and the toggle inputs of the flip-flop bank.

---
 rtl/t_toggle_sequencer.sv | 120 ++++++++++++
 tb/tb_t_toggle_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/t_toggle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : t_toggle_sequencer
// Purpose  : Steps a bank of WIDTH external T flip-flops from its current
//            state to a requested target state. Each cycle it issues at most
//            one one-hot toggle strobe, starting at the LSB, and spaces the
//            strobes GAP idle cycles apart. It keeps a cycle-exact mirror of
//            the bank outputs.
// Ports    : clk, reset           - clock and synchronous active-high reset
//            req_valid/req_ready  - command handshake (accepted only in IDLE)
//            req_target           - requested final bank state
//            t                    - toggle strobes to the bank (zero/one-hot)
//            q_mirror             - copy of the bank state
//            busy, done           - not-IDLE flag, completion pulse
//            toggles              - strobes issued for the latest command
// Revision : 1.0  initial release
// ============================================================================
module t_toggle_sequencer #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [WIDTH-1:0]             req_target,
    output logic                         req_ready,
    output logic [WIDTH-1:0]             t,
    output logic [WIDTH-1:0]             q_mirror,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   toggles
);

    localparam int c_tog_w = $clog2(WIDTH + 1);
    // The gap counter only has to hold GAP-1; keep at least one bit so the
    // GAP=0 and GAP=1 builds still elaborate.
    localparam int c_gap_w = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_gap_m1 = (GAP > 0) ? (GAP - 1) : 0;
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(c_gap_m1);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_toggle = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   r_mirror;
    logic [c_tog_w-1:0] r_toggles;
    logic [c_gap_w-1:0] r_gap_cnt;

    logic [WIDTH-1:0]   w_low;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_req_diff;

    // Isolate the lowest set bit of the pending difference (two's-complement trick).
    assign w_low      = r_diff & (~r_diff + c_one);
    assign w_rem      = r_diff & ~w_low;
    assign w_req_diff = req_target ^ r_mirror;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_diff    <= '0;
            r_mirror  <= '0;
            r_toggles <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_diff    <= w_req_diff;
                        r_toggles <= '0;
                        r_state   <= (w_req_diff == '0) ? c_st_done : c_st_toggle;
                    end
                end
                c_st_toggle: begin
                    // The bank samples t on this same edge, so the mirror
                    // flips in step with it.
                    r_mirror  <= r_mirror ^ w_low;
                    r_diff    <= w_rem;
                    r_toggles <= r_toggles + c_tog_w'(1);
                    if (w_rem == '0) begin
                        r_state <= c_st_done;
                    end else if (GAP == 0) begin
                        r_state <= c_st_toggle;
                    end else begin
                        r_state   <= c_st_wait;
                        r_gap_cnt <= c_gap_load;
                    end
                end
                c_st_wait: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= c_st_toggle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state; only req_ready also looks
    // at reset so that no command can be accepted while reset is asserted.
    assign req_ready = (r_state == c_st_idle) & ~reset;
    assign t         = (r_state == c_st_toggle) ? w_low : '0;
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign q_mirror  = r_mirror;
    assign toggles   = r_toggles;

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_t_toggle_sequencer
// Purpose  : Self-checking bench. Two sequencers (GAP=2 and GAP=0) share one
//            command stream; a schedule-based reference model predicts every
//            output each cycle, and directed sections pin literal values.
// Revision : 1.0  initial release
// ============================================================================
module tb_t_toggle_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_target = 4'b0000;

    logic       d_rdy  [2];
    logic [3:0] d_t    [2];
    logic [3:0] d_q    [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic [2:0] d_tog  [2];

    int vectors = 0;
    int miscompares = 0;
    logic en = 1'b0;

    // Reference model: per instance, a list of expected per-cycle
    // {done, t} entries built at accept time, plus the expected bank state.
    logic [3:0] mq     [2];
    int         mtog   [2];
    int         len    [2];
    int         pos    [2];
    logic [4:0] sched  [2][16];
    logic [3:0] bank   [2];
    logic [3:0] last_t [2];

    always #5 clk = ~clk;

    t_toggle_sequencer #(.WIDTH(4), .GAP(2)) u_dut_gap2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(d_rdy[0]), .t(d_t[0]), .q_mirror(d_q[0]), .busy(d_busy[0]),
        .done(d_done[0]), .toggles(d_tog[0])
    );

    t_toggle_sequencer #(.WIDTH(4), .GAP(0)) u_dut_gap0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(d_rdy[1]), .t(d_t[1]), .q_mirror(d_q[1]), .busy(d_busy[1]),
        .done(d_done[1]), .toggles(d_tog[1])
    );

    function automatic int gapv(input int j);
        return (j == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input int j, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, j, $time, act, exp_v);
        end
    endtask

    task automatic model_step();
        logic [4:0] e;
        logic [3:0] d;
        logic       first;
        for (int j = 0; j < 2; j++) begin
            if (reset) begin
                mq[j] = 4'b0; mtog[j] = 0; len[j] = 0; pos[j] = 0; bank[j] = 4'b0;
            end else begin
                bank[j] = bank[j] ^ last_t[j];
                if (pos[j] < len[j]) begin
                    e = sched[j][pos[j]];
                    if (e[3:0] != 4'b0) begin
                        mq[j] = mq[j] ^ e[3:0];
                        mtog[j]++;
                    end
                    pos[j]++;
                end else if (req_valid) begin
                    d = req_target ^ mq[j];
                    len[j] = 0; pos[j] = 0; mtog[j] = 0; first = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (d[b]) begin
                            if (!first) begin
                                for (int g = 0; g < gapv(j); g++) begin
                                    sched[j][len[j]] = 5'b0;
                                    len[j]++;
                                end
                            end
                            sched[j][len[j]] = 5'(1 << b);
                            len[j]++;
                            first = 1'b0;
                        end
                    end
                    sched[j][len[j]] = 5'b10000;
                    len[j]++;
                end
            end
        end
    endtask

    // Single compare process: every cycle, both instances against the model.
    always @(negedge clk) begin : p_compare
        logic [4:0] front;
        logic       bsy;
        if (en) begin
            for (int j = 0; j < 2; j++) begin
                bsy   = (pos[j] < len[j]);
                front = bsy ? sched[j][pos[j]] : 5'b0;
                chk("t",        j, int'(d_t[j]),    int'(front[3:0]));
                chk("done",     j, int'(d_done[j]), int'(front[4]));
                chk("busy",     j, int'(d_busy[j]), int'(bsy));
                chk("req_ready",j, int'(d_rdy[j]),  int'(!bsy && !reset));
                chk("q_mirror", j, int'(d_q[j]),    int'(mq[j]));
                chk("toggles",  j, int'(d_tog[j]),  mtog[j]);
                chk("bank",     j, int'(d_q[j]),    int'(bank[j]));
            end
        end
        for (int j = 0; j < 2; j++) last_t[j] = d_t[j];
    end

    task automatic tick(input logic v, input logic [3:0] tg, input logic r);
        @(posedge clk);
        model_step();
        #2;
        req_valid  = v;
        req_target = tg;
        reset      = r;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] two_t [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};

    initial begin
        for (int j = 0; j < 2; j++) begin
            last_t[j] = 4'b0; bank[j] = 4'b0; mq[j] = 4'b0;
            mtog[j] = 0; len[j] = 0; pos[j] = 0;
        end

        // Reset held for two cycles.
        tick(1'b0, 4'b0000, 1'b1);
        en = 1'b1;
        at_neg();
        chk("rst_ready", 0, int'(d_rdy[0]), 0);
        chk("rst_t",     0, int'(d_t[0]),   0);
        chk("rst_busy",  0, int'(d_busy[0]),0);
        tick(1'b0, 4'b0000, 1'b1);
        at_neg();
        chk("rst_done",  0, int'(d_done[0]),0);
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("rel_q",     0, int'(d_q[0]),   0);
        chk("rel_ready", 0, int'(d_rdy[0]), 1);

        // Two-bit target 1010 from 0000.
        tick(1'b1, 4'b1010, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, 4'b0000, 1'b0);
            at_neg();
            chk("two_t",    0, int'(d_t[0]),    int'(two_t[i-1]));
            chk("two_done", 0, int'(d_done[0]), (i == 5) ? 1 : 0);
        end
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("two_q",   0, int'(d_q[0]),   int'(4'b1010));
        chk("two_tog", 0, int'(d_tog[0]), 2);

        // No-op command.
        tick(1'b1, 4'b1010, 1'b0);
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("noop_done", 0, int'(d_done[0]), 1);
        chk("noop_t",    0, int'(d_t[0]),    0);
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("noop_tog",  0, int'(d_tog[0]),  0);

        // Full flip 1010 -> 0101 with a 1111 request held while busy.
        tick(1'b1, 4'b0101, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            tick(1'b1, 4'b1111, 1'b0);
            at_neg();
            chk("ff_t",     0, int'(d_t[0]),
                ((i <= 10) && ((i - 1) % 3 == 0)) ? (1 << ((i - 1) / 3)) : 0);
            chk("ff_done",  0, int'(d_done[0]), (i == 11) ? 1 : 0);
            chk("ff_ready", 0, int'(d_rdy[0]),  0);
            if (i <= 5) begin
                chk("ff0_t",    1, int'(d_t[1]),    (i <= 4) ? (1 << (i - 1)) : 0);
                chk("ff0_done", 1, int'(d_done[1]), (i == 5) ? 1 : 0);
            end
        end
        tick(1'b1, 4'b1111, 1'b0);
        at_neg();
        chk("ff_ready_back", 0, int'(d_rdy[0]), 1);
        chk("ff_q",          0, int'(d_q[0]),   int'(4'b0101));
        chk("ff_tog",        0, int'(d_tog[0]), 4);
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("held_accept",   0, int'(d_busy[0]), 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0000, 1'b0);

        // Reset during cycle 5 of a full flip 1111 -> 0000.
        tick(1'b1, 4'b0000, 1'b0);
        for (int i = 1; i <= 3; i++) tick(1'b0, 4'b0000, 1'b0);
        tick(1'b0, 4'b0000, 1'b1);
        at_neg();
        chk("mid_ready", 0, int'(d_rdy[0]), 0);
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("mid_q",    0, int'(d_q[0]),    0);
        chk("mid_t",    0, int'(d_t[0]),    0);
        chk("mid_busy", 0, int'(d_busy[0]), 0);
        chk("mid_done", 0, int'(d_done[0]), 0);
        tick(1'b0, 4'b0000, 1'b0);
        at_neg();
        chk("mid_nodone", 0, int'(d_done[0]), 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 39) == 0));
        end
        tick(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 15; i++) tick(1'b0, 4'b0000, 1'b0);
        at_neg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
